// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests under req/gnt/rvalid,
// buffers responses for decode and handles branch redirects with stale-response draining.
//   state   | meaning
//   S_IDLE  | one cycle after reset release, no requests
//   S_FETCH | issuing requests, buffering responses
//   S_DRAIN | after a redirect, waiting for stale responses; all dropped
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  input  logic        i_if_ready,
  input  logic        i_br_valid,
  input  logic        i_br_jump,
  input  logic [31:0] i_br_target,
  output logic        o_flush
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d, dpc_q, dpc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d, cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     fifo_q [DEPTH];
  logic            flush_q;
  logic            redir, gnt, rsp, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_imem_req  = (state_q == S_FETCH) & ~i_stall & ((out_cnt_q + cnt_q) < DEPTH_C);
  assign o_imem_addr = pc_q & WORD_MASK;
  assign o_if_valid  = (cnt_q != '0);
  assign o_if_instr  = fifo_q[rd_ptr_q];
  assign o_if_pc     = dpc_q;
  assign o_flush     = flush_q;

  assign redir = i_br_valid & i_br_jump & (state_q != S_IDLE);
  assign gnt   = o_imem_req & i_imem_gnt;
  assign rsp   = i_imem_rvalid & (out_cnt_q != '0);
  // Responses landing in the redirect cycle belong to the old path
  assign push  = i_imem_rvalid & (state_q == S_FETCH) & ~redir & (cnt_q < DEPTH_C);
  assign pop   = o_if_valid & i_if_ready & ~redir;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dpc_d     = dpc_q;
    out_cnt_d = out_cnt_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    case ({gnt, rsp})
      2'b10:   if (out_cnt_q < DEPTH_C) out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: ;
    endcase

    if (redir) begin
      pc_d     = i_br_target & WORD_MASK;
      dpc_d    = i_br_target & WORD_MASK;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (gnt) pc_d = pc_q + 32'd4;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dpc_d    = dpc_q + 32'd4;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (redir && (out_cnt_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (out_cnt_d == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC & WORD_MASK;
      dpc_q     <= RESET_PC;
      out_cnt_q <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dpc_q     <= dpc_d;
      out_cnt_q <= out_cnt_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      flush_q   <= redir;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= i_imem_rdata;
    end
  end

  a_rsp_outstanding: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_imem_rvalid |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait memory model with a response hold switch,
// in-order delivery scoreboard, and hand-computed checks for reset, stall and redirect cases.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, req, gnt, rvalid, valid, ready, br_valid, br_jump, flush;
  logic [31:0] addr, rdata, instr, if_pc, br_target;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          p0;
  logic [31:0] exp_pc = 32'h0;
  bit          rsp_en;
  logic [31:0] mq[$];

  fetch_sequencer #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_stall(stall),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_if_valid(valid), .o_if_instr(instr), .o_if_pc(if_pc), .i_if_ready(ready),
    .i_br_valid(br_valid), .i_br_jump(br_jump), .i_br_target(br_target),
    .o_flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Grants are recorded mid-cycle, responses issued on the following edge
  always @(negedge clk) if (rstn && req && gnt) mq.push_back(addr);

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else if (rsp_en && mq.size() != 0) begin
      rvalid <= 1'b1;
      rdata  <= instr_of(mq[0]);
      mq.pop_front();
    end else begin
      rvalid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rstn) exp_pc = 32'h0;
    else if (br_valid && br_jump) exp_pc = br_target & 32'hFFFF_FFFC;
    else if (valid && ready) begin
      check("deliver_pc", if_pc, exp_pc);
      check("deliver_instr", instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
  end

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    while (!req && n < lim) begin smp(); n++; end
    check("req_wait", 32'(n < lim), 32'd1);
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!valid && n < lim) begin smp(); n++; end
    check("valid_wait", 32'(n < lim), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    drv(); br_valid = 1'b1; br_jump = 1'b1; br_target = t;
    drv(); br_valid = 1'b0; br_jump = 1'b0;
    smp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; stall = 1'b0; gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1;
    br_valid = 1'b0; br_jump = 1'b0; br_target = 32'h0;
    #12;
    check("rst_req", 32'(req), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_flush", 32'(flush), 32'd0);
    #1 rstn = 1'b1;

    // streaming from reset
    smp(); check("c1_req", 32'(req), 32'd1); check("c1_addr", addr, 32'h0);
    smp(); check("c2_addr", addr, 32'h4); check("c2_valid", 32'(valid), 32'd0);
    smp(); check("c3_valid", 32'(valid), 32'd1); check("c3_pc", if_pc, 32'h0);
    check("c3_req", 32'(req), 32'd0);
    drv(); p0 = pops;
    repeat (9) smp();
    check("rate", 32'((pops - p0) >= 4), 32'd1);

    // backpressure fills the buffer
    drv(); ready = 1'b0;
    repeat (10) smp();
    check("full_req", 32'(req), 32'd0);
    check("full_valid", 32'(valid), 32'd1);
    check("full_pc", if_pc, exp_pc);
    drv(); ready = 1'b1;
    repeat (8) smp();

    // stall: pending responses still delivered; redirect with nothing outstanding
    drv(); stall = 1'b1;
    smp(); check("stall_req", 32'(req), 32'd0);
    repeat (5) smp();
    check("stall_req2", 32'(req), 32'd0);
    check("stall_empty", 32'(valid), 32'd0);
    redirect(32'h203);
    check("r203_flush", 32'(flush), 32'd1);
    check("r203_pc", if_pc, 32'h200);
    check("r203_req", 32'(req), 32'd0);
    drv(); stall = 1'b0;
    smp(); check("r203_req2", 32'(req), 32'd1); check("r203_addr", addr, 32'h200);
    check("r203_flush0", 32'(flush), 32'd0);
    repeat (6) smp();

    // redirect with two requests outstanding
    drv(); rsp_en = 1'b0;
    repeat (6) smp();
    check("hold_req", 32'(req), 32'd0);
    redirect(32'h100);
    check("r100_flush", 32'(flush), 32'd1);
    check("r100_req", 32'(req), 32'd0);
    check("r100_valid", 32'(valid), 32'd0);
    check("r100_pc", if_pc, 32'h100);
    smp(); check("r100_flush0", 32'(flush), 32'd0); check("drain_req", 32'(req), 32'd0);
    drv(); rsp_en = 1'b1;
    wait_req(20); check("r100_addr", addr, 32'h100);
    wait_valid(20); check("r100_ifpc", if_pc, 32'h100);
    check("r100_instr", instr, instr_of(32'h100));

    // second redirect during DRAIN wins
    repeat (4) smp();
    drv(); rsp_en = 1'b0;
    repeat (6) smp();
    redirect(32'h203);
    check("d1_flush", 32'(flush), 32'd1); check("d1_pc", if_pc, 32'h200);
    smp(); check("d1_flush0", 32'(flush), 32'd0);
    redirect(32'h400);
    check("d2_flush", 32'(flush), 32'd1); check("d2_pc", if_pc, 32'h400);
    check("d2_req", 32'(req), 32'd0);
    drv(); rsp_en = 1'b1;
    wait_req(20); check("d2_addr", addr, 32'h400);
    wait_valid(20); check("d2_ifpc", if_pc, 32'h400);

    // asynchronous reset while draining
    repeat (4) smp();
    drv(); rsp_en = 1'b0;
    repeat (6) smp();
    drv(); br_valid = 1'b1; br_jump = 1'b1; br_target = 32'h80;
    drv(); br_valid = 1'b0; br_jump = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("ar_req", 32'(req), 32'd0);
    check("ar_addr", addr, 32'h0);
    check("ar_valid", 32'(valid), 32'd0);
    check("ar_instr", instr, 32'h0);
    check("ar_pc", if_pc, 32'h0);
    check("ar_flush", 32'(flush), 32'd0);
    repeat (2) drv();
    rsp_en = 1'b1; rstn = 1'b1;
    smp(); check("ar_idle_req", 32'(req), 32'd0);
    smp(); check("ar_req1", 32'(req), 32'd1); check("ar_addr1", addr, 32'h0);
    wait_valid(10); check("ar_ifpc", if_pc, 32'h0); check("ar_instr1", instr, instr_of(32'h0));
    repeat (5) smp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
